// File: rtl/ppbus_phy.sv
// rtl/ppbus_phy.sv - Pi parallel-port handshake engine with transmit FIFO
module ppbus_phy #(
    parameter int NSYNC  = 2,
    parameter int LGFLEN = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic       o_rx_stb,
    output logic [7:0] o_rx_data,
    input  logic       i_tx_stb,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_busy,
    input  logic       i_pp_dir,
    input  logic       i_pp_clk,
    input  logic [7:0] i_pp_data,
    output logic [7:0] o_pp_data,
    output logic       o_pp_oe,
    output logic       o_pp_clkfb
);

    localparam int              DEPTH    = 1 << LGFLEN;
    localparam logic [LGFLEN:0] CNT_FULL = (LGFLEN+1)'(DEPTH);
    localparam logic [LGFLEN:0] CNT_ONE  = (LGFLEN+1)'(1);
    localparam logic [LGFLEN-1:0] PTR_ONE = LGFLEN'(1);

    // Pin synchronizers: equal depth so data is stable whenever s_clk moves.
    logic [NSYNC-1:0]      clk_sync_q, clk_sync_d;
    logic [NSYNC-1:0]      dir_sync_q, dir_sync_d;
    logic [NSYNC-1:0][7:0] data_sync_q, data_sync_d;

    always_comb begin
        clk_sync_d  = {clk_sync_q[NSYNC-2:0], i_pp_clk};
        dir_sync_d  = {dir_sync_q[NSYNC-2:0], i_pp_dir};
        data_sync_d = {data_sync_q[NSYNC-2:0], i_pp_data};
    end

    always_ff @(posedge i_clk) begin
        clk_sync_q  <= clk_sync_d;
        dir_sync_q  <= dir_sync_d;
        data_sync_q <= data_sync_d;
    end

    logic       s_clk;
    logic       s_dir;
    logic [7:0] s_data;

    assign s_clk  = clk_sync_q[NSYNC-1];
    assign s_dir  = dir_sync_q[NSYNC-1];
    assign s_data = data_sync_q[NSYNC-1];

    logic              rx_stb_q, rx_stb_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic [7:0]        pp_data_q, pp_data_d;
    logic              pp_oe_q, pp_oe_d;
    logic              clkfb_q, clkfb_d;
    logic              dir_q, dir_d;
    logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
    logic [LGFLEN:0]   count_q, count_d;
    logic [7:0]        fifo_mem_q [DEPTH];

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic pending;
    logic dir_change;

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign push       = i_tx_stb && !fifo_full;
    assign pending    = (s_clk != clkfb_q);
    assign dir_change = (s_dir != dir_q);

    always_comb begin
        rx_stb_d  = 1'b0;
        rx_data_d = rx_data_q;
        pp_data_d = pp_data_q;
        clkfb_d   = clkfb_q;
        pop       = 1'b0;
        dir_d     = s_dir;
        pp_oe_d   = !s_dir;

        // A direction flip drops any in-flight request instead of serving it.
        if (dir_change) begin
            clkfb_d = s_clk;
        end else if (pending) begin
            if (dir_q) begin
                rx_data_d = s_data;
                rx_stb_d  = 1'b1;
                clkfb_d   = s_clk;
            end else if (!fifo_empty) begin
                pp_data_d = fifo_mem_q[rd_ptr_q];
                pop       = 1'b1;
                clkfb_d   = s_clk;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= i_tx_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_stb_q  <= 1'b0;
            rx_data_q <= 8'h00;
            pp_data_q <= 8'h00;
            pp_oe_q   <= 1'b0;
            clkfb_q   <= 1'b0;
            dir_q     <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            rx_stb_q  <= rx_stb_d;
            rx_data_q <= rx_data_d;
            pp_data_q <= pp_data_d;
            pp_oe_q   <= pp_oe_d;
            clkfb_q   <= clkfb_d;
            dir_q     <= dir_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign o_rx_stb   = rx_stb_q;
    assign o_rx_data  = rx_data_q;
    assign o_pp_data  = pp_data_q;
    assign o_pp_oe    = pp_oe_q;
    assign o_pp_clkfb = clkfb_q;
    assign o_tx_busy  = fifo_full;

endmodule
